seq_divider: RTL
================

Name: seq_divider

Overview:
- Multi-cycle radix-2 restoring integer divider; the inverse operation of the ALU's MUL/SMUL/UMUL path.
- Replaces the single-cycle combinational DIV in the datapath.
- The control FSM launches it with `start` and stalls until `done`.
- Delivers a quotient (ALU Result) and a remainder (ALU ResultHi), for signed or unsigned operands.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  launch request; sampled only in IDLE.
- is_signed  in  1  1 = two's-complement divide, 0 = unsigned; sampled with start.
- a  in  WIDTH  dividend; sampled with start.
- b  in  WIDTH  divisor; sampled with start.
- busy  out  1  high from the edge after start is accepted until done.
- done  out  1  single-cycle completion pulse.
- quotient  out  WIDTH  result; held stable from done until the next accepted start.
- remainder  out  WIDTH  result; held stable like quotient.
- div_by_zero  out  1  valid while done=1 and held with the results; 1 if b was 0.

Behaviour:
- Reset, asynchronous: state=IDLE; busy, done, div_by_zero=0; quotient, remainder=0; internal counter and working registers=0.
- States: IDLE, CALC, FIX.
- IDLE:
  - done=0 except in the cycle immediately after FIX.
  - start=1 at an edge with b≠0:
    - Latch |a|, |b| (magnitude only if is_signed), q_neg = is_signed & (a[W-1]^b[W-1]), r_neg = is_signed & a[W-1].
    - Clear the partial remainder; count=WIDTH-1; go to CALC; busy=1.
  - start=1 with b==0:
    - Go directly to FIX with dbz flag set.
    - No CALC cycles.
- CALC, one quotient bit per edge, MSB first:
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor using a WIDTH+1-bit subtract.
  - If non-negative, keep the difference and set the quotient LSB to 1; else restore and set it to 0.
  - Exactly WIDTH edges; counter decrements and wraps to FIX after reaching 0.
- FIX, one edge:
  - quotient = q_neg ? −q : q; remainder = r_neg ? −r : r (truncating division; remainder takes the dividend's sign).
  - busy←0, done←1; go to IDLE.
  - Divide-by-zero: quotient=all ones, remainder=a as sampled (unmodified), div_by_zero=1.
- Latency:
  - Normal: done high in the cycle after edge WIDTH+1 counted from the start-sampling edge (33 edges at WIDTH=32).
  - Divide-by-zero: done high after edge 1.
- done is high for exactly one cycle.
- Signed overflow: MIN / −1 yields quotient=MIN (0x80000000), remainder=0 naturally from the magnitude path. No flag.
- start while busy: ignored; the operation in flight is unaffected.
- start in the same cycle as done: accepted, since the FSM is in IDLE. New results overwrite on the subsequent FIX.
- Reset mid-operation: aborts immediately; no done pulse; outputs return to 0.
- Inputs a, b, is_signed may change freely after the start edge.

Decomposition:
- Package `div_pkg`: state enum {IDLE, CALC, FIX}, default WIDTH constant, counter width $clog2(WIDTH).
- Sub-module `cond_negate` (WIDTH-bit conditional two's-complement).
  - Instanced for operand abs and result sign fix.
- Everything else lives in one module.

Test Plan:
- Unsigned 100 / 7, is_signed=0 → quotient=14, remainder=2, div_by_zero=0, done exactly 33 edges after start, busy high for 32 cycles.
- Signed −7 / 2 → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; signed 7 / −2 → quotient=0xFFFFFFFD, remainder=1.
- 0x1234 / 0, either mode → quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1, done after 1 edge.
- Signed 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0.
- Unsigned 0xFFFFFFFF / 0x10 → quotient=0x0FFFFFFF, remainder=0xF; same operands with is_signed=1 → quotient=0, remainder=0xFFFFFFFF.
- Control and reset:
  - Re-pulse start with new operands at cycle 10 of an operation → ignored; original results delivered.
  - Assert reset at cycle 15 → busy=0, quotient=0, no done.
  - Back-to-back start on the done cycle → second result correct.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential divider (package div_pkg).
package div_pkg;

    // Control states of the divider FSM.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

endpackage

// File: rtl/seq_divider_cond_negate.sv
// WIDTH-bit conditional two's-complement: passes value through, or negates it.
// Used both to take operand magnitudes and to re-apply result signs.
module cond_negate
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    // Negation of the most negative value wraps to itself, which is the
    // correct unsigned magnitude for the restoring core.
    always_comb begin
        result = negate ? -value : value;
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider, one quotient bit per clock.
// Signed operands are reduced to magnitudes on entry and signs restored in FIX.
//
//   state | meaning
//   IDLE  | waiting for start; results held
//   CALC  | WIDTH shift/trial-subtract iterations, MSB first
//   FIX   | apply signs (or divide-by-zero values), pulse done
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dq;
    logic [WIDTH-1:0] dvs;
    logic             q_neg;
    logic             r_neg;
    logic             dbz;

    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] fixed_q;
    logic [WIDTH-1:0] fixed_r;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             accept;
    logic             b_zero;

    cond_negate #(.WIDTH(WIDTH)) u_abs_a (
        .value  (a),
        .negate (is_signed & a[WIDTH-1]),
        .result (abs_a)
    );

    cond_negate #(.WIDTH(WIDTH)) u_abs_b (
        .value  (b),
        .negate (is_signed & b[WIDTH-1]),
        .result (abs_b)
    );

    cond_negate #(.WIDTH(WIDTH)) u_fix_q (
        .value  (dq),
        .negate (q_neg),
        .result (fixed_q)
    );

    cond_negate #(.WIDTH(WIDTH)) u_fix_r (
        .value  (rem),
        .negate (r_neg),
        .result (fixed_r)
    );

    // Shift {rem, dq} left one and trial-subtract the divisor. Since rem < dvs,
    // a WIDTH+1-bit difference has its MSB set exactly when it went negative.
    always_comb begin
        accept  = (state == IDLE) && start;
        b_zero  = (b == '0);
        shifted = {rem, dq[WIDTH-1]};
        trial   = shifted - {1'b0, dvs};
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = b_zero ? FIX : CALC;
                end
            end
            CALC: begin
                if (count == '0) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Working registers: operand capture on accept, one iteration per CALC edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            rem   <= '0;
            dq    <= '0;
            dvs   <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            dbz   <= 1'b0;
        end else if (accept) begin
            if (b_zero) begin
                // rem carries the raw dividend through to the remainder output.
                rem   <= a;
                dq    <= '0;
                dvs   <= '0;
                q_neg <= 1'b0;
                r_neg <= 1'b0;
                dbz   <= 1'b1;
            end else begin
                rem   <= '0;
                dq    <= abs_a;
                dvs   <= abs_b;
                count <= CNT_W'(WIDTH - 1);
                q_neg <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                r_neg <= is_signed & a[WIDTH-1];
                dbz   <= 1'b0;
            end
        end else if (state == CALC) begin
            if (trial[WIDTH]) begin
                rem <= shifted[WIDTH-1:0];
            end else begin
                rem <= trial[WIDTH-1:0];
            end
            dq    <= {dq[WIDTH-2:0], ~trial[WIDTH]};
            count <= count - CNT_W'(1);
        end
    end

    // Outputs: busy tracks CALC one edge late, results update only in FIX.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            busy <= (state == CALC);
            done <= (state == FIX);
            if (state == FIX) begin
                quotient    <= dbz ? '1  : fixed_q;
                remainder   <= dbz ? rem : fixed_r;
                div_by_zero <= dbz;
            end
        end
    end

endmodule
